spi_mem_arbiter: RTL and testbench
==================================

Name: spi_mem_arbiter

Overview:
- Shares one spi_mem data/callback port (FM25L16 FRAM, 64-byte window) between NUM_REQ independent clients.
- Picks one pending request, latches its command, and drives the spi_mem en/valid handshake to completion.
- Returns read data and a completion pulse to the owning client, then re-arbitrates.
- Sits between the client blocks (config loader, event logger, ...) and the single spi_mem instance.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ADDR_W, 6, memory address width; matches spi_mem addr.
- DATA_W, 8, data width; matches spi_mem rd_data/wr_data.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous to clk, active-low.
- req_valid  in  NUM_REQ  per-client request; held high until the matching req_ready pulse.
- req_wr  in  NUM_REQ  per-client command: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  per-client address; client i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-client write data; same packing as req_addr.
- req_ready  out  NUM_REQ  one-cycle accept pulse; one-hot or zero.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning client; one-hot or zero.
- rsp_rdata  out  DATA_W  read data; meaningful in the rsp_valid cycle of a read.
- busy  out  1  high whenever the state is not IDLE.
- mem_en  out  1  to spi_mem en.
- mem_wr_en  out  1  to spi_mem wr_en.
- mem_addr  out  ADDR_W  to spi_mem addr.
- mem_wr_data  out  DATA_W  to spi_mem wr_data.
- mem_rd_data  in  DATA_W  from spi_mem rd_data.
- mem_valid  in  1  from spi_mem valid.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer ptr = 0.
  - Owner register = 0.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states: IDLE, ISSUE, RELEASE.
- IDLE:
  - Arbitration runs only when at least one req_valid bit is set and mem_valid == 0.
  - A stale mem_valid blocks arbitration until it clears.
  - Winner: the first set req_valid bit found searching upward from ptr, wrapping past NUM_REQ-1 to 0.
  - In the next cycle:
    - req_ready[winner] = 1 for exactly one cycle.
    - owner <= winner.
    - mem_wr_en, mem_addr and mem_wr_data are loaded from the winner's slices.
    - mem_en <= 1.
    - State goes to ISSUE.
- Latency: req_valid high in cycle N with the arbiter idle gives req_ready and mem_en high in cycle N+1.
- ISSUE:
  - mem_en, mem_wr_en, mem_addr and mem_wr_data are held stable; client inputs are ignored.
  - On mem_valid == 1, in the next cycle:
    - mem_en <= 0.
    - rsp_valid[owner] = 1 for one cycle.
    - For a read, rsp_rdata <= mem_rd_data; for a write, rsp_rdata holds its previous value.
    - State goes to RELEASE.
- RELEASE:
  - mem_en stays 0 while waiting for mem_valid == 0.
  - When it clears: ptr <= (owner+1) mod NUM_REQ and state goes to IDLE.
  - The minimum gap between two mem_en assertions is 2 cycles.
- A client that drops req_valid before its req_ready is simply not served; there is no error.
- A client may re-raise req_valid in the cycle after req_ready. It is considered at the next IDLE.
- A requester's pending req_valid never starves: it waits at most NUM_REQ-1 other transactions.
- Simultaneous requests are resolved by ptr only; requests arriving mid-transaction wait.
- Reset asserted mid-transaction:
  - On the next clk edge: IDLE, mem_en = 0, all pulses 0, ptr = 0.
  - spi_mem shares the same reset, so no recovery sequence is needed.
- mem_valid is never expected high in IDLE after its release; if it is, the arbiter waits (see IDLE).

Optional Feature:
- Macro SPI_MEM_ARB_PRIO0_EN.
- When defined: requester 0 has fixed top priority and always wins if its req_valid is set in IDLE. The remaining requesters rotate round-robin among themselves; ptr covers indices 1..NUM_REQ-1 and wraps to 1.
- When undefined: pure round-robin over all NUM_REQ requesters, as described in Behaviour.

Test Plan:
- Single read: client 0 reads addr 0x15; the spi_mem model returns 0xA5. Required: req_ready[0] one cycle after req_valid; mem_wr_en = 0 and mem_addr = 0x15 held through ISSUE; rsp_valid[0] one cycle with rsp_rdata = 0xA5; busy low after RELEASE.
- Single write: client 1 writes 0x3C to addr 0x3F. Required: mem_wr_en = 1, mem_wr_data = 0x3C held until mem_valid; rsp_valid[1] pulse; rsp_rdata unchanged from its previous value.
- Contention: both clients request continuously from reset. Required service order is 0,1,0,1; no back-to-back grants to one client while the other waits. With SPI_MEM_ARB_PRIO0_EN, all grants go to 0 while 0 keeps requesting.
- Withdrawal: client 1 raises req_valid for one cycle during client 0's ISSUE and then drops it. Required: client 1 is never granted and mem_en stays 0 after client 0 completes.
- Stale valid: the model holds mem_valid high for 5 cycles after the RELEASE exit while client 0 requests. Required: no req_ready and no mem_en until 1 cycle after mem_valid falls.
- Reset mid-ISSUE: pull rst_n low for 1 cycle while mem_en = 1. Required: the next edge gives mem_en = 0, busy = 0, ptr = 0, and no rsp_valid for the aborted transaction.

Source files
------------

// File: rtl/spi_mem_arbiter_if.sv
// rtl/spi_mem_arbiter_if.sv - client request/response and spi_mem port bundle for spi_mem_arbiter
interface spi_mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      busy;
    logic                      mem_en;
    logic                      mem_wr_en;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wr_data;
    logic [DATA_W-1:0]         mem_rd_data;
    logic                      mem_valid;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, mem_rd_data, mem_valid,
        output req_ready, rsp_valid, rsp_rdata, busy,
               mem_en, mem_wr_en, mem_addr, mem_wr_data
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, mem_rd_data, mem_valid,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               mem_en, mem_wr_en, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - round-robin arbiter sharing one spi_mem port among NUM_REQ clients
// Optional macro SPI_MEM_ARB_PRIO0_EN: client 0 gets fixed top priority, others rotate over 1..NUM_REQ-1.
module spi_mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_mem_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               busy_q, busy_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wr_data_q, mem_wr_data_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   idx_w;
    int                 idx;
    logic [PTR_W-1:0]   ptr_next;

    // Winner search: first set request at or above ptr, wrapping around.
`ifdef SPI_MEM_ARB_PRIO0_EN
    int start_i;
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx     = 0;
        idx_w   = '0;
        start_i = (ptr_q == '0) ? 1 : int'(ptr_q);
        if (bus.req_valid[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                idx = start_i + k;
                if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
                idx_w = PTR_W'(idx);
                if (!found && bus.req_valid[idx_w]) begin
                    found  = 1'b1;
                    winner = idx_w;
                end
            end
        end
    end

    // Serving client 0 does not advance the rotation of the others.
    always_comb begin
        if (owner_q == '0)        ptr_next = ptr_q;
        else if (owner_q == LAST) ptr_next = PTR_W'(1);
        else                      ptr_next = owner_q + 1'b1;
    end
`else
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = PTR_W'(idx);
            if (!found && bus.req_valid[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    always_comb begin
        ptr_next = (owner_q == LAST) ? '0 : owner_q + 1'b1;
    end
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        mem_en_d      = mem_en_q;
        mem_wr_en_d   = mem_wr_en_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        case (state_q)
            IDLE: begin
                // A leftover mem_valid from the previous access blocks a new grant.
                if (found && !bus.mem_valid) begin
                    req_ready_d[winner] = 1'b1;
                    owner_d             = winner;
                    mem_wr_en_d         = bus.req_wr[winner];
                    mem_addr_d          = bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    mem_wr_data_d       = bus.req_wdata[int'(winner)*DATA_W +: DATA_W];
                    mem_en_d            = 1'b1;
                    state_d             = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_valid) begin
                    mem_en_d             = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    if (!mem_wr_en_q) rsp_rdata_d = bus.mem_rd_data;
                    state_d              = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.mem_valid) begin
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            busy_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            busy_q        <= busy_d;
            mem_en_q      <= mem_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.busy        = busy_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - directed self-checking bench for spi_mem_arbiter
module tb_spi_mem_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    spi_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spi_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    logic [1:0] exp_grant [4];

    initial begin
        tests = 0;
        fails = 0;
`ifdef SPI_MEM_ARB_PRIO0_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`endif
        rst_n           = 1'b0;
        bus.req_valid   = '0;
        bus.req_wr      = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.mem_rd_data = '0;
        bus.mem_valid   = 1'b0;
        step();
        step();
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wr_data", 32'(bus.mem_wr_data), 0);
        rst_n = 1'b1;
        step();

        // single read, client 0, addr 0x15 -> 0xA5
        bus.req_valid = 2'b01;
        bus.req_wr    = 2'b00;
        bus.req_addr  = {6'h00, 6'h15};
        step();
        chk("rd_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rd_mem_en", 32'(bus.mem_en), 1);
        chk("rd_mem_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rd_mem_addr", 32'(bus.mem_addr), 32'h15);
        chk("rd_busy", 32'(bus.busy), 1);
        bus.req_valid = 2'b00;
        bus.req_addr  = '0;
        step();
        chk("rd_ready_pulse", 32'(bus.req_ready), 0);
        chk("rd_hold_en", 32'(bus.mem_en), 1);
        chk("rd_hold_addr", 32'(bus.mem_addr), 32'h15);
        chk("rd_hold_wr_en", 32'(bus.mem_wr_en), 0);
        step();
        chk("rd_hold_addr2", 32'(bus.mem_addr), 32'h15);
        bus.mem_valid   = 1'b1;
        bus.mem_rd_data = 8'hA5;
        step();
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'hA5);
        chk("rd_mem_en_off", 32'(bus.mem_en), 0);
        chk("rd_busy_release", 32'(bus.busy), 1);
        bus.mem_valid = 1'b0;
        step();
        chk("rd_rsp_pulse", 32'(bus.rsp_valid), 0);
        chk("rd_busy_idle", 32'(bus.busy), 0);

        // single write, client 1, 0x3C -> addr 0x3F
        bus.req_valid = 2'b10;
        bus.req_wr    = 2'b10;
        bus.req_addr  = {6'h3F, 6'h00};
        bus.req_wdata = {8'h3C, 8'h00};
        step();
        chk("wr_req_ready", 32'(bus.req_ready), 32'h2);
        chk("wr_mem_wr_en", 32'(bus.mem_wr_en), 1);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'h3F);
        chk("wr_mem_wr_data", 32'(bus.mem_wr_data), 32'h3C);
        bus.req_valid = 2'b00;
        bus.req_wr    = 2'b00;
        bus.req_wdata = '0;
        step();
        step();
        chk("wr_hold_wr_en", 32'(bus.mem_wr_en), 1);
        chk("wr_hold_wr_data", 32'(bus.mem_wr_data), 32'h3C);
        chk("wr_hold_en", 32'(bus.mem_en), 1);
        bus.mem_valid   = 1'b1;
        bus.mem_rd_data = 8'h77;
        step();
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("wr_rsp_rdata_kept", 32'(bus.rsp_rdata), 32'hA5);
        bus.mem_valid = 1'b0;
        step();
        chk("wr_busy_idle", 32'(bus.busy), 0);

        // contention: both clients request continuously
        bus.req_valid = 2'b11;
        bus.req_addr  = {6'h22, 6'h11};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cont_grant", 32'(bus.req_ready), 32'(exp_grant[i]));
            chk("cont_mem_en", 32'(bus.mem_en), 1);
            bus.mem_valid = 1'b1;
            step();
            chk("cont_rsp", 32'(bus.rsp_valid), 32'(exp_grant[i]));
            bus.mem_valid = 1'b0;
            step();
            chk("cont_gap_en", 32'(bus.mem_en), 0);
        end
        bus.req_valid = 2'b00;
        step();

        // withdrawal: client 1 pulses req_valid during client 0's ISSUE
        bus.req_valid = 2'b01;
        step();
        chk("wd_grant0", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 2'b10;
        step();
        chk("wd_no_grant1", 32'(bus.req_ready), 0);
        bus.req_valid = 2'b00;
        step();
        bus.mem_valid = 1'b1;
        step();
        chk("wd_rsp0", 32'(bus.rsp_valid), 32'h1);
        bus.mem_valid = 1'b0;
        step();
        step();
        chk("wd_idle_ready", 32'(bus.req_ready), 0);
        chk("wd_idle_en", 32'(bus.mem_en), 0);
        step();
        chk("wd_idle_en2", 32'(bus.mem_en), 0);
        chk("wd_idle_busy", 32'(bus.busy), 0);

        // stale mem_valid in IDLE blocks arbitration
        bus.mem_valid = 1'b1;
        bus.req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stale_no_ready", 32'(bus.req_ready), 0);
            chk("stale_no_en", 32'(bus.mem_en), 0);
        end
        bus.mem_valid = 1'b0;
        step();
        chk("stale_grant", 32'(bus.req_ready), 32'h1);
        chk("stale_en", 32'(bus.mem_en), 1);
        bus.req_valid = 2'b00;
        step();
        chk("mid_issue_en", 32'(bus.mem_en), 1);

        // reset during ISSUE
        rst_n = 1'b0;
        step();
        chk("rstm_mem_en", 32'(bus.mem_en), 0);
        chk("rstm_busy", 32'(bus.busy), 0);
        chk("rstm_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rstm_req_ready", 32'(bus.req_ready), 0);
        rst_n = 1'b1;
        step();
        chk("rstm_no_rsp", 32'(bus.rsp_valid), 0);
        bus.req_valid = 2'b11;
        step();
        chk("rstm_ptr0_grant", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 2'b00;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
